// File: rtl/ysyx_22040237_pkg.sv
// ============================================================================
// Module : ysyx_22040237_pkg
// Brief  : Shared FSM state codes and default widths/reset PC for the IFU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ysyx_22040237_pkg;

  localparam int          c_addr_w   = 64;
  localparam int          c_inst_w   = 32;
  localparam logic [63:0] c_reset_pc = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } ifu_state_e;

endpackage

`default_nettype wire

// File: rtl/ysyx_22040237_ifu.sv
// ============================================================================
// Module : ysyx_22040237_ifu
// Brief  : Instruction fetch unit, one outstanding imem request, valid/ready
//          output to the IDU, redirect with in-flight response discard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_22040237_ifu
  import ysyx_22040237_pkg::*;
#(
  parameter int                ADDR_W   = c_addr_w,
  parameter int                INST_W   = c_inst_w,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(c_reset_pc)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [ADDR_W-1:0] imem_req_addr_o,
  input  logic              imem_resp_valid_i,
  input  logic [INST_W-1:0] imem_resp_data_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o
);

  ifu_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc, w_fetch_pc_nxt;
  logic              r_drop, w_drop_nxt;
  logic [INST_W-1:0] r_inst, w_inst_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] w_redirect_target;

  assign w_redirect_target = redirect_pc_i & ~ADDR_W'(3);

  // Gated by rst so no request is visible while reset is held.
  assign imem_req_valid_o = (r_state == S_REQ) && !rst;
  assign imem_req_addr_o  = r_fetch_pc;
  assign inst_valid_o     = (r_state == S_OUT);
  assign inst_o           = r_inst;
  assign pc_o             = r_pc;

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_drop_nxt     = r_drop;
    w_inst_nxt     = r_inst;
    w_pc_nxt       = r_pc;
    case (r_state)
      S_REQ: begin
        if (imem_req_ready_i) w_state_nxt = S_WAIT;
        if (redirect_valid_i) begin
          w_fetch_pc_nxt = w_redirect_target;
          // An accepted request already targets the stale PC; its response must be dropped.
          if (imem_req_ready_i) w_drop_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (redirect_valid_i) begin
          w_fetch_pc_nxt = w_redirect_target;
          if (imem_resp_valid_i) begin
            w_state_nxt = S_REQ;
            w_drop_nxt  = 1'b0;
          end else begin
            w_drop_nxt  = 1'b1;
          end
        end else if (imem_resp_valid_i) begin
          if (r_drop) begin
            w_state_nxt = S_REQ;
            w_drop_nxt  = 1'b0;
          end else begin
            w_inst_nxt  = imem_resp_data_i;
            w_pc_nxt    = r_fetch_pc;
            w_state_nxt = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (redirect_valid_i) begin
          w_fetch_pc_nxt = w_redirect_target;
          w_state_nxt    = S_REQ;
        end else if (inst_ready_i) begin
          w_fetch_pc_nxt = r_fetch_pc + ADDR_W'(4);
          w_state_nxt    = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_REQ;
      r_fetch_pc <= RESET_PC;
      r_drop     <= 1'b0;
      r_inst     <= '0;
      r_pc       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_drop     <= w_drop_nxt;
      r_inst     <= w_inst_nxt;
      r_pc       <= w_pc_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040237_ifu.sv
// ============================================================================
// Module : tb_ysyx_22040237_ifu
// Brief  : Directed cycle-table bench for the instruction fetch unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ysyx_22040237_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid_i;
  logic [63:0] redirect_pc_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [63:0] imem_req_addr_o;
  logic        imem_resp_valid_i;
  logic [31:0] imem_resp_data_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [63:0] pc_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_22040237_ifu dut (
    .clk               (clk),
    .rst               (rst),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_pc_i     (redirect_pc_i),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_req_addr_o   (imem_req_addr_o),
    .imem_resp_valid_i (imem_resp_valid_i),
    .imem_resp_data_i  (imem_resp_data_i),
    .inst_valid_o      (inst_valid_o),
    .inst_ready_i      (inst_ready_i),
    .inst_o            (inst_o),
    .pc_o              (pc_o)
  );

  // One row = expected outputs in this cycle, then inputs driven for the next edge.
  typedef struct {
    logic        e_req_v;
    logic [63:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [63:0] e_pc;
    logic        req_ready;
    logic        resp_v;
    logic [31:0] resp_data;
    logic        inst_ready;
    logic        redir_v;
    logic [63:0] redir_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic e_req_v, input logic [63:0] e_addr, input logic e_iv,
                     input logic [31:0] e_inst, input logic [63:0] e_pc,
                     input logic req_ready, input logic resp_v, input logic [31:0] resp_data,
                     input logic inst_ready, input logic redir_v, input logic [63:0] redir_pc);
    vec_t v;
    v.e_req_v = e_req_v; v.e_addr = e_addr; v.e_iv = e_iv; v.e_inst = e_inst; v.e_pc = e_pc;
    v.req_ready = req_ready; v.resp_v = resp_v; v.resp_data = resp_data;
    v.inst_ready = inst_ready; v.redir_v = redir_v; v.redir_pc = redir_pc;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_req_v, input logic [63:0] e_addr,
                            input logic e_iv, input logic [31:0] e_inst, input logic [63:0] e_pc);
    check({tag, " req_valid"},  64'(imem_req_valid_o), 64'(e_req_v));
    check({tag, " req_addr"},   imem_req_addr_o,       e_addr);
    check({tag, " inst_valid"}, 64'(inst_valid_o),     64'(e_iv));
    check({tag, " inst"},       64'(inst_o),           64'(e_inst));
    check({tag, " pc"},         pc_o,                  e_pc);
  endtask

  task automatic drive(input logic req_ready, input logic resp_v, input logic [31:0] resp_data,
                       input logic inst_ready, input logic redir_v, input logic [63:0] redir_pc);
    imem_req_ready_i  = req_ready;
    imem_resp_valid_i = resp_v;
    imem_resp_data_i  = resp_data;
    inst_ready_i      = inst_ready;
    redirect_valid_i  = redir_v;
    redirect_pc_i     = redir_pc;
  endtask

  localparam logic [63:0] RPC = 64'h8000_0000;
  localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

  initial begin
    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 0, 64'h0);

    // Normal fetch, IDU back-pressure held 5 cycles, then consume
    add(1, RPC,      0, 32'h0,         64'h0,  1, 0, 32'h0,         0, 0, 64'h0);
    add(0, RPC,      0, 32'h0,         64'h0,  0, 1, 32'h0010_0093, 0, 0, 64'h0);
    for (int i = 0; i < 5; i++)
      add(0, RPC,    1, 32'h0010_0093, RPC,    0, 0, 32'h0,         0, 0, 64'h0);
    add(0, RPC,      1, 32'h0010_0093, RPC,    0, 0, 32'h0,         1, 0, 64'h0);
    // Accepted request, redirect before delayed response -> discarded
    add(1, RPC+4,    0, 32'h0010_0093, RPC,    1, 0, 32'h0,         0, 0, 64'h0);
    add(0, RPC+4,    0, 32'h0010_0093, RPC,    0, 0, 32'h0,         0, 1, RPC+'h100);
    add(0, RPC+'h100,0, 32'h0010_0093, RPC,    0, 0, 32'h0,         0, 0, 64'h0);
    add(0, RPC+'h100,0, 32'h0010_0093, RPC,    0, 1, 32'hDEAD_BEEF, 0, 0, 64'h0);
    // Redirect coinciding with IDU handshake -> target wins over pc+4
    add(1, RPC+'h100,0, 32'h0010_0093, RPC,    1, 0, 32'h0,         0, 0, 64'h0);
    add(0, RPC+'h100,0, 32'h0010_0093, RPC,    0, 1, 32'h0020_0113, 0, 0, 64'h0);
    add(0, RPC+'h100,1, 32'h0020_0113, RPC+'h100, 0, 0, 32'h0,      1, 1, RPC+'h100);
    // Unaligned redirect while request not accepted; then PC wrap
    add(1, RPC+'h100,0, 32'h0020_0113, RPC+'h100, 0, 0, 32'h0,      0, 1, 64'hFFFF_FFFF_FFFF_FFFE);
    add(1, TOP,      0, 32'h0020_0113, RPC+'h100, 1, 0, 32'h0,      0, 0, 64'h0);
    add(0, TOP,      0, 32'h0020_0113, RPC+'h100, 0, 1, 32'h0000_0013, 0, 0, 64'h0);
    add(0, TOP,      1, 32'h0000_0013, TOP,    0, 0, 32'h0,         1, 0, 64'h0);
    // Redirect on accepted request plus stray response in S_REQ
    add(1, 64'h0,    0, 32'h0000_0013, TOP,    1, 1, 32'h0BAD_0BAD, 0, 1, RPC+'h200);
    add(0, RPC+'h200,0, 32'h0000_0013, TOP,    0, 1, 32'h0BAD_0BAD, 0, 0, 64'h0);
    // Redirect coinciding with a response in S_WAIT
    add(1, RPC+'h200,0, 32'h0000_0013, TOP,    1, 0, 32'h0,         0, 0, 64'h0);
    add(0, RPC+'h200,0, 32'h0000_0013, TOP,    0, 1, 32'h0030_0193, 0, 1, RPC+'h300);
    // Redirect kills held instruction without handshake
    add(1, RPC+'h300,0, 32'h0000_0013, TOP,    1, 0, 32'h0,         0, 0, 64'h0);
    add(0, RPC+'h300,0, 32'h0000_0013, TOP,    0, 1, 32'h0040_0213, 0, 0, 64'h0);
    add(0, RPC+'h300,1, 32'h0040_0213, RPC+'h300, 0, 0, 32'h0,      0, 1, RPC+'h400);
    add(1, RPC+'h400,0, 32'h0040_0213, RPC+'h300, 0, 0, 32'h0,      0, 0, 64'h0);
    add(1, RPC+'h400,0, 32'h0040_0213, RPC+'h300, 0, 0, 32'h0,      0, 0, 64'h0);

    repeat (2) @(negedge clk);
    check_outs("reset", 0, RPC, 0, 32'h0, 64'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      check_outs($sformatf("row%0d", i), vecs[i].e_req_v, vecs[i].e_addr, vecs[i].e_iv,
                 vecs[i].e_inst, vecs[i].e_pc);
      drive(vecs[i].req_ready, vecs[i].resp_v, vecs[i].resp_data,
            vecs[i].inst_ready, vecs[i].redir_v, vecs[i].redir_pc);
    end

    // Reset asserted while waiting for a response; stale response after release
    @(negedge clk);
    drive(1, 0, 32'h0, 0, 0, 64'h0);
    @(negedge clk);
    check("midrst pre req_valid", 64'(imem_req_valid_o), 64'h0);
    drive(0, 0, 32'h0, 0, 0, 64'h0);
    rst = 1'b1;
    #1;
    check_outs("midrst async", 0, RPC, 0, 32'h0, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1, 32'hBAD1_BAD1, 0, 0, 64'h0);
    @(negedge clk);
    check_outs("stale", 1, RPC, 0, 32'h0, 64'h0);
    drive(1, 0, 32'h0, 0, 0, 64'h0);
    @(negedge clk);
    check_outs("refetch wait", 0, RPC, 0, 32'h0, 64'h0);
    drive(0, 1, 32'h0010_0093, 0, 0, 64'h0);
    @(negedge clk);
    check_outs("refetch out", 0, RPC, 1, 32'h0010_0093, RPC);
    drive(0, 0, 32'h0, 0, 0, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
